alu: RTL and testbench

- Datapath ALU of the CPU core.
- Combines the accumulator and the data operand under a 3-bit opcode and produces a combinational result plus an accumulator-zero flag.
- Also provides a registered copy of result and flags, captured on the clock when enabled, for the pipeline/status logic.

---
 rtl/alu.sv | 72 +++++++
 tb/tb_alu.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Datapath ALU: combines accum and data under a 3-bit opcode, with a
// combinational result/zero flag and an enable-captured registered copy.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] accum,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [WIDTH-1:0] out_r,
  output logic             zero_r,
  output logic             carry_r
);

  typedef enum logic [2:0] {
    OP_PASS0 = 3'b000,
    OP_PASS1 = 3'b001,
    OP_ADD   = 3'b010,
    OP_AND   = 3'b011,
    OP_XOR   = 3'b100,
    OP_PASSD = 3'b101,
    OP_PASS6 = 3'b110,
    OP_PASS7 = 3'b111
  } op_t;

  logic [WIDTH:0] sum;
  logic           carry;

  assign sum  = {1'b0, accum} + {1'b0, data};
  assign zero = (accum == '0);

  // An X/Z opcode matches no item and falls through to X so it stays visible.
  always_comb begin
    out   = 'x;
    carry = 1'b0;
    case (opcode)
      OP_PASS0: out = accum;
      OP_PASS1: out = accum;
      OP_ADD: begin
        out   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_AND:   out = accum & data;
      OP_XOR:   out = accum ^ data;
      OP_PASSD: out = data;
      OP_PASS6: out = accum;
      OP_PASS7: out = accum;
      default: begin
        out   = 'x;
        carry = 1'b0;
      end
    endcase
  end

  // Reset takes priority over the capture enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r   <= '0;
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
    end else if (en) begin
      out_r   <= out;
      zero_r  <= zero;
      carry_r <= carry;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan steps followed by random
// stimulus, all compared against an arithmetic reference model.
module tb_alu;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] accum;
  logic             en;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic [WIDTH-1:0] out_r;
  logic             zero_r;
  logic             carry_r;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_out_r   = 0;
  int exp_zero_r  = 0;
  int exp_carry_r = 0;

  alu #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .data    (data),
    .accum   (accum),
    .en      (en),
    .out     (out),
    .zero    (zero),
    .out_r   (out_r),
    .zero_r  (zero_r),
    .carry_r (carry_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from the opcode table, using plain integer arithmetic.
  function automatic int model_out(input int op, input int a, input int d);
    case (op)
      2:       return (a + d) % 256;
      3:       return a & d;
      4:       return a ^ d;
      5:       return d;
      default: return a;
    endcase
  endfunction

  function automatic int model_carry(input int op, input int a, input int d);
    return (op == 2 && (a + d) > 255) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs mid-cycle and check the combinational outputs.
  task automatic applyStimulus(input int op, input int d, input int a, input int e, input int r,
                               input string tag);
    opcode = op[2:0];
    data   = d[WIDTH-1:0];
    accum  = a[WIDTH-1:0];
    en     = e[0];
    rst    = r[0];
    #1;
    check({tag, ".out"}, {24'd0, out}, model_out(op, a, d));
    check({tag, ".zero"}, {31'd0, zero}, (a == 0) ? 1 : 0);
  endtask

  // Advance one clock, update the register model, and check registered outputs.
  task automatic checkOutput(input string tag);
    @(posedge clk);
    if (rst) begin
      exp_out_r = 0; exp_zero_r = 0; exp_carry_r = 0;
    end else if (en) begin
      exp_out_r   = model_out(int'(opcode), int'(accum), int'(data));
      exp_zero_r  = (accum == 0) ? 1 : 0;
      exp_carry_r = model_carry(int'(opcode), int'(accum), int'(data));
    end
    #1;
    check({tag, ".out_r"}, {24'd0, out_r}, exp_out_r);
    check({tag, ".zero_r"}, {31'd0, zero_r}, exp_zero_r);
    check({tag, ".carry_r"}, {31'd0, carry_r}, exp_carry_r);
  endtask

  initial begin
    opcode = 3'b000; data = '0; accum = '0; en = 1'b0; rst = 1'b1;
    @(negedge clk);

    applyStimulus(0, 8'hFF, 8'h00, 0, 1, "reset");
    checkOutput("reset");

    applyStimulus(0, 8'hFF, 8'h00, 1, 0, "pass0_zero");
    applyStimulus(0, 8'hFF, 8'h55, 1, 0, "pass0");
    applyStimulus(1, 8'h00, 8'hCC, 1, 0, "pass1");
    applyStimulus(2, 8'hAA, 8'h33, 1, 0, "add_nc");
    applyStimulus(2, 8'h05, 8'h00, 1, 0, "add_zero");
    applyStimulus(2, 8'h20, 8'hF0, 1, 0, "add_carry");
    checkOutput("add_carry");
    check("add_carry.out_r_const", {24'd0, out_r}, 32'h10);
    check("add_carry.carry_const", {31'd0, carry_r}, 32'h1);

    applyStimulus(3, 8'h33, 8'h0F, 1, 0, "and");
    applyStimulus(4, 8'h55, 8'hF0, 1, 0, "xor");
    applyStimulus(5, 8'hAA, 8'h00, 1, 0, "passd_aa");
    applyStimulus(5, 8'hCC, 8'h00, 1, 0, "passd_cc");
    checkOutput("passd_cc");
    applyStimulus(6, 8'hF0, 8'hFF, 1, 0, "pass6");
    applyStimulus(7, 8'h0F, 8'hCC, 1, 0, "pass7");
    checkOutput("pass7");

    applyStimulus(0, 8'h00, 8'h00, 0, 1, "rst_mid");
    checkOutput("rst_mid");
    applyStimulus(2, 8'hFF, 8'hFF, 0, 0, "hold1");
    checkOutput("hold1");
    applyStimulus(4, 8'h12, 8'h34, 0, 0, "hold2");
    checkOutput("hold2");
    applyStimulus(2, 8'hFF, 8'h02, 1, 0, "cap_carry");
    checkOutput("cap_carry");
    applyStimulus(2, 8'hFF, 8'h02, 1, 1, "rst_wins");
    checkOutput("rst_wins");

    for (int i = 0; i < 300; i++) begin
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                    ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0) ? 1 : 0, "rand");
      checkOutput("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
